// File: rtl/fact_pkg.sv
// Shared types and constants for the fact_sched factorial scheduler.
package fact_pkg;
    localparam int NUM_REQ = 2;
    localparam int N_W     = 4;
    localparam int RES_W   = 32;

    localparam logic [RES_W-1:0] RES_MAX = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;
endpackage

// File: rtl/fact_sched_if.sv
// Request/response bundle between requesters and the factorial scheduler.
interface fact_sched_if;
    logic [fact_pkg::NUM_REQ-1:0]             req_valid;
    logic [fact_pkg::NUM_REQ*fact_pkg::N_W-1:0] req_n;
    logic [fact_pkg::NUM_REQ-1:0]             req_ready;
    logic                                     resp_valid;
    logic                                     resp_ready;
    logic                                     resp_id;
    logic [fact_pkg::RES_W-1:0]               result;
    logic                                     ovf;
    logic                                     busy;

    modport master (
        output req_valid, req_n, resp_ready,
        input  req_ready, resp_valid, resp_id, result, ovf, busy
    );

    modport slave (
        input  req_valid, req_n, resp_ready,
        output req_ready, resp_valid, resp_id, result, ovf, busy
    );
endinterface

// File: rtl/fact_rr_arb.sv
// Two-way round-robin arbiter with one-hot combinational grant.
module fact_rr_arb
    import fact_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] i_req_valid,
    input  logic               i_en,
    output logic [NUM_REQ-1:0] o_grant,
    output logic               o_grant_id
);
    logic r_ptr;
    logic w_pick;

    // Pointer only matters on contention; a lone request wins outright.
    always_comb begin
        w_pick = i_req_valid[1];
        if (&i_req_valid) begin
            w_pick = r_ptr;
        end
    end

    always_comb begin
        o_grant    = '0;
        o_grant_id = w_pick;
        if (i_en && (|i_req_valid)) begin
            o_grant = w_pick ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ptr <= 1'b0;
        end else if (|o_grant) begin
            r_ptr <= ~o_grant_id;
        end
    end
endmodule

// File: rtl/fact_sched.sv
// Round-robin scheduler around an iterative 32-bit factorial datapath.
// Optional saturation on overflow: define FACT_SAT_EN.
module fact_sched
    import fact_pkg::*;
(
    input logic         clk,
    input logic         reset,
    fact_sched_if.slave bus
);
    state_t             r_state;
    state_t             w_next;
    logic [N_W-1:0]     r_cnt;
    logic [RES_W-1:0]   r_acc;
    logic               r_id;
    logic [NUM_REQ-1:0] w_grant;
    logic               w_gid;
    logic               w_en;
    logic               w_accept;
    logic [N_W-1:0]     w_n;

    // Gating with reset keeps req_ready low while reset is held.
    assign w_en     = (r_state == IDLE) && reset;
    assign w_accept = |w_grant;
    assign w_n      = w_gid ? bus.req_n[2*N_W-1:N_W] : bus.req_n[N_W-1:0];

    fact_rr_arb u_arb (
        .clk         (clk),
        .reset       (reset),
        .i_req_valid (bus.req_valid),
        .i_en        (w_en),
        .o_grant     (w_grant),
        .o_grant_id  (w_gid)
    );

`ifdef FACT_SAT_EN
    logic [2*RES_W-1:0] w_prod;
    logic               r_ovf;
    assign w_prod = {{RES_W{1'b0}}, r_acc}
                  * {{(2*RES_W-N_W){1'b0}}, r_cnt};
`else
    logic [RES_W-1:0] w_prod;
    assign w_prod = r_acc * {{(RES_W-N_W){1'b0}}, r_cnt};
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: if (w_accept) w_next = CALC;
            CALC: if (r_cnt <= N_W'(1)) w_next = DONE;
            DONE: if (bus.resp_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
            r_acc <= '0;
            r_id  <= 1'b0;
`ifdef FACT_SAT_EN
            r_ovf <= 1'b0;
`endif
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_cnt <= w_n;
                        r_acc <= RES_W'(1);
                        r_id  <= w_gid;
`ifdef FACT_SAT_EN
                        r_ovf <= 1'b0;
`endif
                    end
                end
                CALC: begin
                    if (r_cnt > N_W'(1)) begin
                        r_cnt <= r_cnt - 1'b1;
`ifdef FACT_SAT_EN
                        // Once saturated, acc is pinned for the rest of the run.
                        if (r_ovf || (|w_prod[2*RES_W-1:RES_W])) begin
                            r_acc <= RES_MAX;
                            r_ovf <= 1'b1;
                        end else begin
                            r_acc <= w_prod[RES_W-1:0];
                        end
`else
                        r_acc <= w_prod;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready  = w_grant;
    assign bus.resp_valid = (r_state == DONE);
    assign bus.resp_id    = r_id;
    assign bus.result     = r_acc;
    assign bus.busy       = (r_state != IDLE);
`ifdef FACT_SAT_EN
    assign bus.ovf        = r_ovf;
`else
    assign bus.ovf        = 1'b0;
`endif
endmodule

// File: tb/tb_fact_sched.sv
// Directed self-checking bench for fact_sched.
module tb_fact_sched;
    import fact_pkg::*;

    logic clk;
    logic reset;
    int   n_chk;
    int   n_fail;

    fact_sched_if bus ();

    fact_sched dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_rst_outs(input string tag);
        check({tag, "_rdy"},  64'(bus.req_ready),  64'd0);
        check({tag, "_rv"},   64'(bus.resp_valid), 64'd0);
        check({tag, "_id"},   64'(bus.resp_id),    64'd0);
        check({tag, "_res"},  64'(bus.result),     64'd0);
        check({tag, "_ovf"},  64'(bus.ovf),        64'd0);
        check({tag, "_busy"}, 64'(bus.busy),       64'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset          = 1'b0;
        bus.req_valid  = '0;
        bus.resp_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_rst_outs("reset");
        reset = 1'b1;
    endtask

    task automatic present(input int id, input logic [3:0] n);
        bus.req_valid[id]       = 1'b1;
        bus.req_n[id*4 +: 4]    = n;
    endtask

    // Called at a negedge with requests presented.
    task automatic accept(input logic [1:0] exp_gnt);
        int t;
        t = 0;
        #1;
        while (bus.req_ready == 2'b00 && t < 40) begin
            @(posedge clk);
            @(negedge clk);
            t++;
        end
        check("req_ready", 64'(bus.req_ready), 64'(exp_gnt));
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = bus.req_valid & ~exp_gnt;
    endtask

    task automatic collect(input int n, input logic [31:0] exp_res,
                           input logic exp_id, input logic exp_ovf,
                           input int hold);
        int lat;
        int exp_lat;
        lat     = 1;
        exp_lat = ((n < 1) ? 1 : n) + 1;
        while (!bus.resp_valid && lat < 40) begin
            check("busy", 64'(bus.busy), 64'd1);
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        check("latency", 64'(lat), 64'(exp_lat));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("hold_rv",  64'(bus.resp_valid), 64'd1);
            check("hold_res", 64'(bus.result),     64'(exp_res));
            check("hold_id",  64'(bus.resp_id),    64'(exp_id));
            check("hold_rdy", 64'(bus.req_ready),  64'd0);
        end
        check("result", 64'(bus.result),  64'(exp_res));
        check("resp_id", 64'(bus.resp_id), 64'(exp_id));
        check("ovf", 64'(bus.ovf), 64'(exp_ovf));
        check("busy_done", 64'(bus.busy), 64'd1);
        bus.resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.resp_ready = 1'b0;
        check("rv_clear", 64'(bus.resp_valid), 64'd0);
        check("idle", 64'(bus.busy), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] e13;
        logic [31:0] e15;
        logic        eo;
        int          seen;
        n_chk          = 0;
        n_fail         = 0;
        reset          = 1'b0;
        bus.req_valid  = '0;
        bus.req_n      = '0;
        bus.resp_ready = 1'b0;
        #3;
        check_rst_outs("por");

        do_reset();
        present(0, 4'd5);
        accept(2'b01);
        collect(5, 32'h78, 1'b0, 1'b0, 0);

        do_reset();
        for (int r = 0; r < 2; r++) begin
            present(0, 4'd3);
            present(1, 4'd4);
            accept(2'b01);
            collect(3, 32'd6, 1'b0, 1'b0, 0);
            accept(2'b10);
            collect(4, 32'd24, 1'b1, 1'b0, 0);
        end

        present(0, 4'd0);
        accept(2'b01);
        collect(0, 32'd1, 1'b0, 1'b0, 0);
        present(0, 4'd1);
        accept(2'b01);
        collect(1, 32'd1, 1'b0, 1'b0, 0);

`ifdef FACT_SAT_EN
        e13 = 32'hFFFF_FFFF;
        e15 = 32'hFFFF_FFFF;
        eo  = 1'b1;
`else
        e13 = 32'h7328_CC00;
        e15 = 32'h7777_5800;
        eo  = 1'b0;
`endif
        present(1, 4'd12);
        accept(2'b10);
        collect(12, 32'h1C8C_FC00, 1'b1, 1'b0, 0);
        present(1, 4'd13);
        accept(2'b10);
        collect(13, e13, 1'b1, eo, 0);
        present(0, 4'd15);
        accept(2'b01);
        collect(15, e15, 1'b0, eo, 0);

        present(0, 4'd2);
        accept(2'b01);
        present(1, 4'd3);
        collect(2, 32'd2, 1'b0, 1'b0, 10);
        accept(2'b10);
        collect(3, 32'd6, 1'b1, 1'b0, 0);

        present(0, 4'd10);
        accept(2'b01);
        repeat (3) @(negedge clk);
        bus.req_valid[1] = 1'b1;
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_rst_outs("async");
        @(negedge clk);
        bus.req_valid = '0;
        @(negedge clk);
        reset = 1'b1;
        seen  = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.resp_valid) seen++;
        end
        check("no_resp", 64'(seen), 64'd0);
        present(0, 4'd4);
        accept(2'b01);
        collect(4, 32'd24, 1'b0, 1'b0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/fact_sched.md
# fact_sched

Round-robin scheduler that shares one iterative 32-bit factorial datapath between two requesters. Each requester hands over a 4-bit operand n with a valid/ready handshake. The block computes n! one multiply per cycle and returns the result, tagged with the requester id, through a held-valid response port. It sits in front of the factorial datapath and is the only block allowed to sequence it.

## Interface
Parameters:
- NUM_REQ, 2, number of requesters (fixed at 2 in this revision)
- N_W, 4, operand width
- RES_W, 32, result width

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- req_valid  in  2  per-requester request valid
- req_n  in  8  operands, packed: requester i on bits [4i+3:4i]
- req_ready  out  2  one-hot accept strobe, combinational
- resp_valid  out  1  result available
- resp_ready  in  1  consumer accepts result
- resp_id  out  1  requester that owns the result
- result  out  32  n!
- ovf  out  1  result exceeded 32 bits (see Configuration)
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, CALC, DONE.
- IDLE: if any req_valid is high, the arbiter grants one requester and asserts its req_ready bit in the same cycle.
  - On that edge: latch n into cnt, set acc=1, clear ovf, record resp_id, move to CALC.
- CALC: if cnt<=1, move to DONE. Otherwise, acc<=acc*cnt (64-bit product) and cnt<=cnt-1.
- DONE: resp_valid=1. result, resp_id and ovf are held stable until resp_ready=1. On that edge, return to IDLE.
- Arbitration: round-robin.
  - Pointer resets to 0.
  - With both requests valid, grant the pointer's requester.
  - After any grant, the pointer points to the other requester.
  - With a single request valid, grant it regardless of the pointer.
- Requester rules: req_valid and its req_n must be held stable until req_ready. req_valid may not be withdrawn. req_ready is never asserted outside IDLE.
- 0! = 1! = 1.

## Timing
- Reset values (asynchronous, reset low):
  - outputs: req_ready=0, resp_valid=0, resp_id=0, result=0, ovf=0, busy=0
  - internal: state=IDLE, pointer=0
- Latency: resp_valid rises max(n,1)+1 cycles after the accept edge. Examples: n=0 gives 2, n=5 gives 6, n=15 gives 16.
- Throughput: at most one request in flight. The next accept can happen at the earliest one cycle after the resp_ready handshake edge.
- Back-to-back requests: a request presented during CALC or DONE waits. No request is lost, and no request is granted twice.
- Reset mid-operation: the computation is aborted immediately and no response is issued. Pending requesters must re-present.
- resp_ready arriving while not in DONE is ignored.

## Configuration
- FACT_SAT_EN defined:
  - If the upper 32 bits of any product are nonzero, ovf is set and stays set (sticky).
  - acc is forced to 32'hFFFFFFFF for the rest of the computation.
  - result=32'hFFFFFFFF and ovf=1 for n>=13.
- FACT_SAT_EN undefined:
  - acc keeps the low 32 bits of each product (modulo 2^32).
  - ovf is tied to 0.

## Structure
- fact_pkg holds:
  - the state enum (IDLE, CALC, DONE)
  - constants N_W=4, RES_W=32, NUM_REQ=2
  - the saturation constant RES_MAX=32'hFFFFFFFF
- Sub-module fact_rr_arb contains the round-robin pointer and combinational one-hot grant logic.
  - Inputs: req_valid, enable (state==IDLE).
  - Outputs: grant[1:0], grant_id.
- fact_sched holds the FSM, cnt, acc, the multiplier and the response registers.

## Test plan
- Reset, then req0 with n=5 and resp_ready=1: req_ready=2'b01 in the accept cycle. result=32'h78, resp_id=0 after 6 cycles, busy high throughout.
- Both requests valid in the same cycle (n0=3, n1=4), repeated twice: grants go 0,1,0,1. Results are 6 (id 0), 24 (id 1), then the same pair again.
- n=0 and n=1: result=1 for both, resp_valid 2 cycles after accept.
- n=12: result=32'h1C8CFC00, ovf=0. Then n=13 and n=15:
  - without FACT_SAT_EN: 32'h7328CC00 and 32'h77775800, ovf=0
  - with FACT_SAT_EN: 32'hFFFFFFFF, ovf=1
- Hold resp_ready=0 for 10 cycles in DONE with req1 valid: result and resp_id stay stable, req_ready stays 0. Raise resp_ready: req1 is accepted no earlier than the following cycle.
- Drive reset low during CALC of n=10: all outputs go to reset values asynchronously and no resp_valid follows. After release, a fresh req0 with n=4 returns 24.
